// File: rtl/sprite_compositor_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared constants and types for the sprite compositor slice.
//   RGB_W        default colour channel width
//   SCREEN_W/H   active raster size the renderers are built for
//   LAYER_PLAYER layer index that carries the player sprite (top priority)
//   rgb_t        packed {r,g,b} pixel
//   layer_t      one renderer output: colour plus opaque-pixel flag
// -----------------------------------------------------------------------------
package sprite_pkg;

  localparam int RGB_W        = 8;
  localparam int SCREEN_W     = 1280;
  localparam int SCREEN_H     = 720;
  localparam int LAYER_PLAYER = 0;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t rgb;
    logic hit;
  } layer_t;

endpackage

// File: rtl/sprite_compositor_if.sv
// -----------------------------------------------------------------------------
// sprite_compositor_if
// Pixel bus into and out of the compositor.
//   i_de/i_h_sync/i_v_sync   video timing from the renderers
//   i_layer_rgb              NUM_LAYERS x {R,G,B}, layer k at [k*3*RGB_W +: 3*RGB_W]
//   i_layer_hit              per-layer opaque flag
//   i_bg_rgb                 background {R,G,B}
//   o_red/o_green/o_blue     composited pixel
//   o_de/o_h_sync/o_v_sync   timing aligned to the composited pixel
//   o_collision              previous frame contained a player/obstacle overlap
//   o_collision_count        saturating count of colliding frames
// Modports: master = pixel source / sink side, slave = compositor.
// -----------------------------------------------------------------------------
interface sprite_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_W      = 8,
  parameter int CNT_W      = 16
);

  logic                         i_de;
  logic                         i_h_sync;
  logic                         i_v_sync;
  logic [NUM_LAYERS*3*RGB_W-1:0] i_layer_rgb;
  logic [NUM_LAYERS-1:0]        i_layer_hit;
  logic [3*RGB_W-1:0]           i_bg_rgb;

  logic [RGB_W-1:0]             o_red;
  logic [RGB_W-1:0]             o_green;
  logic [RGB_W-1:0]             o_blue;
  logic                         o_de;
  logic                         o_h_sync;
  logic                         o_v_sync;
  logic                         o_collision;
  logic [CNT_W-1:0]             o_collision_count;

  modport master (
    output i_de, i_h_sync, i_v_sync, i_layer_rgb, i_layer_hit, i_bg_rgb,
    input  o_red, o_green, o_blue, o_de, o_h_sync, o_v_sync,
           o_collision, o_collision_count
  );

  modport slave (
    input  i_de, i_h_sync, i_v_sync, i_layer_rgb, i_layer_hit, i_bg_rgb,
    output o_red, o_green, o_blue, o_de, o_h_sync, o_v_sync,
           o_collision, o_collision_count
  );

endinterface

// File: rtl/sprite_compositor_priority_mux.sv
// -----------------------------------------------------------------------------
// sprite_priority_mux
// Purely combinational lowest-index-wins layer selector.
//   layer_rgb_i  NUM_LAYERS x {R,G,B}
//   layer_hit_i  per-layer opaque flag
//   bg_rgb_i     colour used when no layer is opaque
//   rgb_o        selected colour
//   win_idx_o    index of the winning layer (0 when none)
//   win_hit_o    1 when some layer won, 0 when background was chosen
// -----------------------------------------------------------------------------
module sprite_priority_mux #(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_W      = 8,
  parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS*3*RGB_W-1:0] layer_rgb_i,
  input  logic [NUM_LAYERS-1:0]         layer_hit_i,
  input  logic [3*RGB_W-1:0]            bg_rgb_i,
  output logic [3*RGB_W-1:0]            rgb_o,
  output logic [IDX_W-1:0]              win_idx_o,
  output logic                          win_hit_o
);

  logic [3*RGB_W-1:0] layer_arr [NUM_LAYERS];

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_unpack
    assign layer_arr[gi] = layer_rgb_i[gi*3*RGB_W +: 3*RGB_W];
  end

  // Walk from the bottom layer upward so the last assignment, i.e. the
  // lowest opaque index, is the one that sticks.
  always_comb begin
    rgb_o     = bg_rgb_i;
    win_idx_o = '0;
    win_hit_o = 1'b0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layer_hit_i[k]) begin
        rgb_o     = layer_arr[k];
        win_idx_o = IDX_W'(k);
        win_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// -----------------------------------------------------------------------------
// sprite_compositor
// Merges NUM_LAYERS sprite layers over a background into one pixel stream and
// reports player-vs-obstacle overlap once per frame.
// Ports:
//   i_clk  pixel clock
//   i_rst  asynchronous active-high reset
//   bus    sprite_compositor_if.slave (pixel inputs, composited outputs,
//          collision flag and counter)
// Pipeline: stage 1 registers all inputs, stage 2 registers the selected
// colour and delayed timing; total latency 2 cycles.
// Build option: define SPRITE_COMP_FLASH_EN to invert player-won pixels while
// o_collision is set.
// -----------------------------------------------------------------------------
module sprite_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_W      = sprite_pkg::RGB_W,
  parameter int CNT_W      = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  sprite_compositor_if.slave bus
);

  import sprite_pkg::*;

  localparam int PIX_W = 3 * RGB_W;
  localparam int IDX_W = $clog2(NUM_LAYERS);

  // Stage 1
  logic                          de_s1_q, hs_s1_q, vs_s1_q;
  logic [NUM_LAYERS*PIX_W-1:0]   layer_rgb_s1_q;
  logic [NUM_LAYERS-1:0]         hit_s1_q;
  logic [PIX_W-1:0]              bg_s1_q;

  // Stage 2
  logic                          de_s2_q, hs_s2_q, vs_s2_q;
  logic [PIX_W-1:0]              rgb_s2_q, rgb_d;

  // Frame collision tracking
  logic                          vs_prev_q;
  logic                          acc_q, acc_d;
  logic                          coll_q, coll_d;
  logic [CNT_W-1:0]              count_q, count_d;

  logic [PIX_W-1:0]              mux_rgb;
  logic [IDX_W-1:0]              win_idx;
  logic                          win_hit;
  logic [PIX_W-1:0]              pix_rgb;
  logic                          overlap;
  logic                          frame_edge;

  sprite_priority_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .RGB_W      (RGB_W),
    .IDX_W      (IDX_W)
  ) u_mux (
    .layer_rgb_i (layer_rgb_s1_q),
    .layer_hit_i (hit_s1_q),
    .bg_rgb_i    (bg_s1_q),
    .rgb_o       (mux_rgb),
    .win_idx_o   (win_idx),
    .win_hit_o   (win_hit)
  );

`ifdef SPRITE_COMP_FLASH_EN
  logic flash;
  assign flash   = coll_q & win_hit & (win_idx == IDX_W'(LAYER_PLAYER));
  assign pix_rgb = flash ? ~mux_rgb : mux_rgb;
`else
  // The winner index only drives the flash path; keep it visibly consumed.
  logic unused_win;
  assign unused_win = ^{win_idx, win_hit};
  assign pix_rgb    = mux_rgb;
`endif

  assign overlap    = de_s1_q & hit_s1_q[LAYER_PLAYER] & (|hit_s1_q[NUM_LAYERS-1:1]);
  assign frame_edge = vs_s1_q & ~vs_prev_q;

  always_comb begin
    rgb_d   = de_s1_q ? pix_rgb : '0;
    acc_d   = acc_q | overlap;
    coll_d  = coll_q;
    count_d = count_q;
    if (frame_edge) begin
      coll_d = acc_q;
      // A pixel arriving on the boundary cycle starts the new frame's record.
      acc_d  = overlap;
      if (acc_q && (count_q != {CNT_W{1'b1}})) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      de_s1_q        <= 1'b0;
      hs_s1_q        <= 1'b0;
      vs_s1_q        <= 1'b0;
      layer_rgb_s1_q <= '0;
      hit_s1_q       <= '0;
      bg_s1_q        <= '0;
      de_s2_q        <= 1'b0;
      hs_s2_q        <= 1'b0;
      vs_s2_q        <= 1'b0;
      rgb_s2_q       <= '0;
      vs_prev_q      <= 1'b0;
      acc_q          <= 1'b0;
      coll_q         <= 1'b0;
      count_q        <= '0;
    end else begin
      de_s1_q        <= bus.i_de;
      hs_s1_q        <= bus.i_h_sync;
      vs_s1_q        <= bus.i_v_sync;
      layer_rgb_s1_q <= bus.i_layer_rgb;
      hit_s1_q       <= bus.i_layer_hit;
      bg_s1_q        <= bus.i_bg_rgb;
      de_s2_q        <= de_s1_q;
      hs_s2_q        <= hs_s1_q;
      vs_s2_q        <= vs_s1_q;
      rgb_s2_q       <= rgb_d;
      vs_prev_q      <= vs_s1_q;
      acc_q          <= acc_d;
      coll_q         <= coll_d;
      count_q        <= count_d;
    end
  end

  assign bus.o_red             = rgb_s2_q[3*RGB_W-1 -: RGB_W];
  assign bus.o_green           = rgb_s2_q[2*RGB_W-1 -: RGB_W];
  assign bus.o_blue            = rgb_s2_q[RGB_W-1 -: RGB_W];
  assign bus.o_de              = de_s2_q;
  assign bus.o_h_sync          = hs_s2_q;
  assign bus.o_v_sync          = vs_s2_q;
  assign bus.o_collision       = coll_q;
  assign bus.o_collision_count = count_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// -----------------------------------------------------------------------------
// tb_sprite_compositor
// Drives two compositor instances from the same stimulus: the main one with a
// 16-bit collision counter and a second with a 2-bit counter so saturation is
// reachable in a few frames. Pixel-stream checks use an expected-value queue
// filled as stimulus is driven and drained as the 2-cycle pipeline delivers.
// -----------------------------------------------------------------------------
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de  = 1'b0;
  logic        hs  = 1'b0;
  logic        vs  = 1'b0;
  logic [3:0]  hit = 4'b0000;
  logic [95:0] layer_rgb = '0;
  logic [23:0] bg = '0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t exp_q[$];

`ifdef SPRITE_COMP_FLASH_EN
  localparam logic [23:0] P0_WIN = 24'hEDCBA9;
`else
  localparam logic [23:0] P0_WIN = 24'h123456;
`endif

  sprite_compositor_if #(.NUM_LAYERS(4), .RGB_W(8), .CNT_W(16)) bus ();
  sprite_compositor_if #(.NUM_LAYERS(4), .RGB_W(8), .CNT_W(2))  bus2 ();

  assign bus.i_de         = de;
  assign bus.i_h_sync     = hs;
  assign bus.i_v_sync     = vs;
  assign bus.i_layer_rgb  = layer_rgb;
  assign bus.i_layer_hit  = hit;
  assign bus.i_bg_rgb     = bg;
  assign bus2.i_de        = de;
  assign bus2.i_h_sync    = hs;
  assign bus2.i_v_sync    = vs;
  assign bus2.i_layer_rgb = layer_rgb;
  assign bus2.i_layer_hit = hit;
  assign bus2.i_bg_rgb    = bg;

  sprite_compositor #(.NUM_LAYERS(4), .RGB_W(8), .CNT_W(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  sprite_compositor #(.NUM_LAYERS(4), .RGB_W(8), .CNT_W(2)) dut_sat (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; hit = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic px(input logic d, input logic [3:0] h);
    @(negedge clk);
    de = d; hit = h; hs = 1'b0;
  endtask

  task automatic frame_edge(input int hold);
    @(negedge clk);
    de = 1'b0; hit = 4'b0000; vs = 1'b1;
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    vs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({bus.o_red, bus.o_green, bus.o_blue} !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=000000", {bus.o_red, bus.o_green, bus.o_blue}); end
    total++; if ({bus.o_de, bus.o_h_sync, bus.o_v_sync} !== 3'b000) begin bad++; $display("FAIL reset_sync got=%b exp=000", {bus.o_de, bus.o_h_sync, bus.o_v_sync}); end
    total++; if (bus.o_collision !== 1'b0) begin bad++; $display("FAIL reset_collision got=%b exp=0", bus.o_collision); end
    total++; if (bus.o_collision_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%h exp=0000", bus.o_collision_count); end
    total++; if (bus2.o_collision_count !== 2'h0) begin bad++; $display("FAIL reset_count_sat got=%h exp=0", bus2.o_collision_count); end
    $display("reset: outputs checked");
    rst = 1'b0;
  endtask

  task automatic test_priority();
    logic [31:0] tbl [11];
    exp_t        e;
    logic [26:0] obs;
    int          n;
    // {de,hs,vs,0} | hit | expected RGB
    tbl = '{32'h83FF0000, 32'h80000080, 32'h84123ABC, 32'h88ABCDEF,
            32'h8600FF00, 32'h8FFF0000, 32'h0F000000, 32'h4F000000,
            32'h0F000000, 32'h8A00FF00, 32'h2F000000};
    n = 11;
    apply_reset();
    layer_rgb = {24'hABCDEF, 24'h123ABC, 24'h00FF00, 24'hFF0000};
    bg        = 24'h000080;
    for (int c = 0; c < n + 2; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        e   = exp_q.pop_front();
        obs = {bus.o_red, bus.o_green, bus.o_blue, bus.o_de, bus.o_h_sync, bus.o_v_sync};
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL priority[%0d] got rgb=%h de/hs/vs=%b exp rgb=%h de/hs/vs=%b",
                   c - 2, obs[26:3], obs[2:0], e.rgb, {e.de, e.hs, e.vs});
        end else begin
          $display("priority[%0d] rgb=%h de/hs/vs=%b", c - 2, obs[26:3], obs[2:0]);
        end
      end
      if (c < n) begin
        de = tbl[c][31]; hs = tbl[c][30]; vs = tbl[c][29]; hit = tbl[c][27:24];
        exp_q.push_back({tbl[c][23:0], tbl[c][31], tbl[c][30], tbl[c][29]});
      end else begin
        de = 1'b0; hs = 1'b0; vs = 1'b0; hit = 4'b0000;
      end
    end
  endtask

  task automatic test_collision();
    apply_reset();
    px(1'b1, 4'b0011);
    px(1'b0, 4'b0000);
    frame_edge(2);
    total++; if (bus.o_collision !== 1'b1) begin bad++; $display("FAIL coll_frameA got=%b exp=1", bus.o_collision); end
    total++; if (bus.o_collision_count !== 16'd1) begin bad++; $display("FAIL count_frameA got=%0d exp=1", bus.o_collision_count); end
    $display("collision frame A: coll=%b count=%0d", bus.o_collision, bus.o_collision_count);
    px(1'b1, 4'b0001);
    px(1'b1, 4'b0010);
    px(1'b1, 4'b1000);
    px(1'b0, 4'b0000);
    frame_edge(2);
    total++; if (bus.o_collision !== 1'b0) begin bad++; $display("FAIL coll_frameB got=%b exp=0", bus.o_collision); end
    total++; if (bus.o_collision_count !== 16'd1) begin bad++; $display("FAIL count_frameB got=%0d exp=1", bus.o_collision_count); end
    $display("collision frame B: coll=%b count=%0d", bus.o_collision, bus.o_collision_count);
  endtask

  task automatic test_no_overlap();
    apply_reset();
    px(1'b1, 4'b0110);
    px(1'b0, 4'b0011);
    px(1'b0, 4'b1111);
    px(1'b0, 4'b0000);
    for (int f = 0; f < 2; f++) begin
      frame_edge(2);
      total++; if (bus.o_collision !== 1'b0) begin bad++; $display("FAIL noovl_coll[%0d] got=%b exp=0", f, bus.o_collision); end
      total++; if (bus.o_collision_count !== 16'd0) begin bad++; $display("FAIL noovl_count[%0d] got=%0d exp=0", f, bus.o_collision_count); end
      $display("no-overlap frame %0d: coll=%b count=%0d", f, bus.o_collision, bus.o_collision_count);
    end
  endtask

  task automatic test_vsync_hold();
    apply_reset();
    px(1'b1, 4'b0011);
    px(1'b0, 4'b0000);
    @(negedge clk);
    vs = 1'b1; de = 1'b0; hit = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5 || i == 12) begin de = 1'b1; hit = 4'b0011; end
      else begin de = 1'b0; hit = 4'b0000; end
    end
    @(negedge clk);
    vs = 1'b0; de = 1'b0; hit = 4'b0000;
    repeat (3) @(negedge clk);
    total++; if (bus.o_collision !== 1'b1) begin bad++; $display("FAIL hold_coll got=%b exp=1", bus.o_collision); end
    total++; if (bus.o_collision_count !== 16'd1) begin bad++; $display("FAIL hold_count got=%0d exp=1", bus.o_collision_count); end
    $display("vsync hold: coll=%b count=%0d", bus.o_collision, bus.o_collision_count);
    px(1'b1, 4'b0001);
    px(1'b0, 4'b0000);
    frame_edge(2);
    total++; if (bus.o_collision !== 1'b1) begin bad++; $display("FAIL hold_next_coll got=%b exp=1", bus.o_collision); end
    total++; if (bus.o_collision_count !== 16'd2) begin bad++; $display("FAIL hold_next_count got=%0d exp=2", bus.o_collision_count); end
    frame_edge(2);
    total++; if (bus.o_collision !== 1'b0) begin bad++; $display("FAIL hold_clean_coll got=%b exp=0", bus.o_collision); end
    total++; if (bus.o_collision_count !== 16'd2) begin bad++; $display("FAIL hold_clean_count got=%0d exp=2", bus.o_collision_count); end
    $display("vsync hold follow-up: coll=%b count=%0d", bus.o_collision, bus.o_collision_count);
  endtask

  task automatic test_coincident();
    apply_reset();
    px(1'b1, 4'b0001);
    px(1'b0, 4'b0000);
    @(negedge clk);
    vs = 1'b1; de = 1'b1; hit = 4'b0011;
    @(negedge clk);
    de = 1'b0; hit = 4'b0000;
    repeat (2) @(negedge clk);
    vs = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.o_collision !== 1'b0) begin bad++; $display("FAIL coinc_coll got=%b exp=0", bus.o_collision); end
    total++; if (bus.o_collision_count !== 16'd0) begin bad++; $display("FAIL coinc_count got=%0d exp=0", bus.o_collision_count); end
    frame_edge(2);
    total++; if (bus.o_collision !== 1'b1) begin bad++; $display("FAIL coinc_next_coll got=%b exp=1", bus.o_collision); end
    total++; if (bus.o_collision_count !== 16'd1) begin bad++; $display("FAIL coinc_next_count got=%0d exp=1", bus.o_collision_count); end
    $display("coincident overlap: coll=%b count=%0d", bus.o_collision, bus.o_collision_count);
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat;
    apply_reset();
    for (int f = 1; f <= 5; f++) begin
      px(1'b1, 4'b0011);
      px(1'b0, 4'b0000);
      frame_edge(2);
      exp_sat = (f < 3) ? 2'(f) : 2'd3;
      total++; if (bus2.o_collision_count !== exp_sat) begin bad++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", f, bus2.o_collision_count, exp_sat); end
      total++; if (bus.o_collision_count !== 16'(f)) begin bad++; $display("FAIL wide_count[%0d] got=%0d exp=%0d", f, bus.o_collision_count, f); end
      $display("saturation frame %0d: narrow=%0d wide=%0d", f, bus2.o_collision_count, bus.o_collision_count);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    layer_rgb = {24'hABCDEF, 24'h123ABC, 24'h00FF00, 24'hFF0000};
    px(1'b1, 4'b0011);
    px(1'b0, 4'b0000);
    frame_edge(2);
    px(1'b1, 4'b0011);
    px(1'b1, 4'b0010);
    @(negedge clk);
    #2;
    rst = 1'b1; de = 1'b0; hit = 4'b0000;
    #1;
    total++; if ({bus.o_red, bus.o_green, bus.o_blue, bus.o_de} !== 25'h0) begin bad++; $display("FAIL midrst_pixel got=%h exp=0", {bus.o_red, bus.o_green, bus.o_blue, bus.o_de}); end
    total++; if (bus.o_collision !== 1'b0) begin bad++; $display("FAIL midrst_coll got=%b exp=0", bus.o_collision); end
    total++; if (bus.o_collision_count !== 16'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", bus.o_collision_count); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    px(1'b1, 4'b0001);
    px(1'b0, 4'b0000);
    frame_edge(2);
    total++; if (bus.o_collision !== 1'b0) begin bad++; $display("FAIL postrst_coll got=%b exp=0", bus.o_collision); end
    total++; if (bus.o_collision_count !== 16'd0) begin bad++; $display("FAIL postrst_count got=%0d exp=0", bus.o_collision_count); end
    $display("mid-frame reset: coll=%b count=%0d", bus.o_collision, bus.o_collision_count);
  endtask

  task automatic test_flash();
    logic [31:0] tbl [6];
    exp_t        e;
    logic [26:0] obs;
    int          n;
    tbl = '{{8'h81, P0_WIN}, 32'h82654321, {8'h83, P0_WIN},
            32'h80000080, 32'h01000000, {8'hC1, P0_WIN}};
    n = 6;
    apply_reset();
    layer_rgb = {24'hABCDEF, 24'h123ABC, 24'h654321, 24'h123456};
    bg        = 24'h000080;
    px(1'b1, 4'b0011);
    px(1'b0, 4'b0000);
    frame_edge(2);
    total++; if (bus.o_collision !== 1'b1) begin bad++; $display("FAIL flash_coll got=%b exp=1", bus.o_collision); end
    for (int c = 0; c < n + 2; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        e   = exp_q.pop_front();
        obs = {bus.o_red, bus.o_green, bus.o_blue, bus.o_de, bus.o_h_sync, bus.o_v_sync};
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL flash[%0d] got rgb=%h de/hs/vs=%b exp rgb=%h de/hs/vs=%b",
                   c - 2, obs[26:3], obs[2:0], e.rgb, {e.de, e.hs, e.vs});
        end else begin
          $display("flash[%0d] rgb=%h de/hs/vs=%b", c - 2, obs[26:3], obs[2:0]);
        end
      end
      if (c < n) begin
        de = tbl[c][31]; hs = tbl[c][30]; vs = tbl[c][29]; hit = tbl[c][27:24];
        exp_q.push_back({tbl[c][23:0], tbl[c][31], tbl[c][30], tbl[c][29]});
      end else begin
        de = 1'b0; hs = 1'b0; vs = 1'b0; hit = 4'b0000;
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_collision();
    test_no_overlap();
    test_vsync_hold();
    test_coincident();
    test_saturation();
    test_reset_mid();
    test_flash();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
